// File: rtl/serial_pattern_tx_if.sv
// Bundles the frame-control inputs and serial/status outputs of serial_pattern_tx.
// The slave modport is the transmitter's view and the master modport is the driver's view.
interface serial_pattern_tx_if #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = 16
);
   logic              i_tx_en_n;
   logic [DATA_W-1:0] i_seed;
   logic              o_serial_data;
   logic              o_serial_valid;
   logic              o_busy;
   logic              o_done;
   logic              o_seq_detected;
   logic [CNT_W-1:0]  o_seq_count;

   modport master (
      output i_tx_en_n, i_seed,
      input  o_serial_data, o_serial_valid, o_busy, o_done, o_seq_detected, o_seq_count
   );

   modport slave (
      input  i_tx_en_n, i_seed,
      output o_serial_data, o_serial_valid, o_busy, o_done, o_seq_detected, o_seq_count
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter with an in-line pattern detector.
// A falling edge on i_tx_en_n starts a frame of NUM_WORDS incrementing words,
// which are shifted out back to back, one bit per clock. Matches of PATTERN
// within the frame are counted by a saturating counter.
module serial_pattern_tx #(
   parameter int               DATA_W    = 10,
   parameter int               NUM_WORDS = 16,
   parameter int               PAT_W     = 4,
   parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
   parameter bit               MSB_FIRST = 1'b1,
   parameter bit               OVERLAP   = 1'b1,
   parameter int               CNT_W     = 16
) (
   input logic          i_clk,
   input logic          i_rst,
   serial_pattern_tx_if.slave bus
);

   localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BIT_W  = $clog2(DATA_W);
   localparam int FILL_W = $clog2(PAT_W + 1);

   localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(NUM_WORDS - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t            r_state;
   logic              r_tx_en_n_d;
   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] r_shift;
   logic [IDX_W-1:0]  r_word_idx;
   logic [BIT_W-1:0]  r_bit_idx;
   logic [PAT_W-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_det;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_start;
   logic              w_bit;
   logic [DATA_W-1:0] w_shift_next;
   logic [PAT_W-1:0]  w_hist_next;
   logic [FILL_W-1:0] w_fill_next;
   logic              w_match;

   assign w_start      = r_tx_en_n_d & ~bus.i_tx_en_n;
   assign w_bit        = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
   assign w_shift_next = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                   : {1'b0, r_shift[DATA_W-1:1]};
   // The cast keeps the low PAT_W bits, which also covers a 1-bit pattern.
   assign w_hist_next  = PAT_W'({r_hist, w_bit});
   assign w_fill_next  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
   assign w_match      = (w_fill_next == FILL_FULL) && (w_hist_next == PATTERN);

   // Frame FSM, shifter, detector and registered status outputs.
   // NOTE: every register here uses <= so all updates see pre-edge values, like real flops.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_tx_en_n_d <= 1'b1;
         r_word      <= '0;
         r_shift     <= '0;
         r_word_idx  <= '0;
         r_bit_idx   <= '0;
         r_hist      <= '0;
         r_fill      <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_det       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_tx_en_n_d <= bus.i_tx_en_n;
         r_det       <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_word     <= bus.i_seed;
                  r_word_idx <= '0;
                  r_cnt      <= '0;
                  r_hist     <= '0;
                  r_fill     <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_shift   <= r_word;
               r_bit_idx <= '0;
               r_valid   <= 1'b1;
               r_state   <= S_SHIFT;
            end
            S_SHIFT: begin
               // Detector consumes the bit on the line this cycle.
               r_hist <= w_hist_next;
               r_fill <= (w_match && !OVERLAP) ? '0 : w_fill_next;
               if (w_match) begin
                  r_det <= 1'b1;
                  if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               end
               if (r_bit_idx == LAST_BIT) begin
                  r_bit_idx <= '0;
                  if (r_word_idx == LAST_WORD) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     // Next word goes straight into the shifter so there is no gap.
                     r_word     <= r_word + 1'b1;
                     r_shift    <= r_word + 1'b1;
                     r_word_idx <= r_word_idx + 1'b1;
                  end
               end else begin
                  r_bit_idx <= r_bit_idx + 1'b1;
                  r_shift   <= w_shift_next;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_serial_data  = w_bit;
   assign bus.o_serial_valid = r_valid;
   assign bus.o_busy         = r_busy;
   assign bus.o_done         = r_done;
   assign bus.o_seq_detected = r_det;
   assign bus.o_seq_count    = r_cnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx across five parameter sets.
// A behavioural model pushes the expected bit/detect/count stream into queues
// when a frame is launched; samples taken on the falling clock edge pop and compare.
module tb_serial_pattern_tx;

   // Per-instance configuration used by the model (must match the instances below).
   localparam int CFG_DW  [5] = '{4, 5, 5, 4, 4};
   localparam int CFG_NW  [5] = '{2, 1, 1, 2, 2};
   localparam int CFG_PW  [5] = '{4, 3, 3, 4, 1};
   localparam int CFG_PAT [5] = '{11, 5, 5, 11, 1};
   localparam int CFG_MSB [5] = '{1, 1, 1, 0, 1};
   localparam int CFG_OV  [5] = '{1, 1, 0, 1, 1};
   localparam int CFG_CW  [5] = '{16, 16, 16, 16, 2};

   logic clk;
   logic rst;
   logic       tx_en_n [5];
   logic [7:0] seed_v  [5];

   logic [4:0]  obs_data, obs_valid, obs_busy, obs_done, obs_det;
   logic [15:0] obs_cnt [5];

   int n_checks;
   int n_errors;

   bit q_bit [$];
   bit q_det [$];
   int q_cnt [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_pattern_tx_if #(.DATA_W(4), .CNT_W(16)) if_a ();
   serial_pattern_tx_if #(.DATA_W(5), .CNT_W(16)) if_b ();
   serial_pattern_tx_if #(.DATA_W(5), .CNT_W(16)) if_c ();
   serial_pattern_tx_if #(.DATA_W(4), .CNT_W(16)) if_d ();
   serial_pattern_tx_if #(.DATA_W(4), .CNT_W(2))  if_e ();

   serial_pattern_tx #(.DATA_W(4), .NUM_WORDS(2), .PAT_W(4), .PATTERN(4'b1011),
                       .MSB_FIRST(1'b1), .OVERLAP(1'b1), .CNT_W(16))
      u_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
   serial_pattern_tx #(.DATA_W(5), .NUM_WORDS(1), .PAT_W(3), .PATTERN(3'b101),
                       .MSB_FIRST(1'b1), .OVERLAP(1'b1), .CNT_W(16))
      u_b (.i_clk(clk), .i_rst(rst), .bus(if_b));
   serial_pattern_tx #(.DATA_W(5), .NUM_WORDS(1), .PAT_W(3), .PATTERN(3'b101),
                       .MSB_FIRST(1'b1), .OVERLAP(1'b0), .CNT_W(16))
      u_c (.i_clk(clk), .i_rst(rst), .bus(if_c));
   serial_pattern_tx #(.DATA_W(4), .NUM_WORDS(2), .PAT_W(4), .PATTERN(4'b1011),
                       .MSB_FIRST(1'b0), .OVERLAP(1'b1), .CNT_W(16))
      u_d (.i_clk(clk), .i_rst(rst), .bus(if_d));
   serial_pattern_tx #(.DATA_W(4), .NUM_WORDS(2), .PAT_W(1), .PATTERN(1'b1),
                       .MSB_FIRST(1'b1), .OVERLAP(1'b1), .CNT_W(2))
      u_e (.i_clk(clk), .i_rst(rst), .bus(if_e));

   assign if_a.i_tx_en_n = tx_en_n[0];
   assign if_b.i_tx_en_n = tx_en_n[1];
   assign if_c.i_tx_en_n = tx_en_n[2];
   assign if_d.i_tx_en_n = tx_en_n[3];
   assign if_e.i_tx_en_n = tx_en_n[4];
   assign if_a.i_seed = seed_v[0][3:0];
   assign if_b.i_seed = seed_v[1][4:0];
   assign if_c.i_seed = seed_v[2][4:0];
   assign if_d.i_seed = seed_v[3][3:0];
   assign if_e.i_seed = seed_v[4][3:0];

   assign obs_data  = {if_e.o_serial_data, if_d.o_serial_data, if_c.o_serial_data,
                       if_b.o_serial_data, if_a.o_serial_data};
   assign obs_valid = {if_e.o_serial_valid, if_d.o_serial_valid, if_c.o_serial_valid,
                       if_b.o_serial_valid, if_a.o_serial_valid};
   assign obs_busy  = {if_e.o_busy, if_d.o_busy, if_c.o_busy, if_b.o_busy, if_a.o_busy};
   assign obs_done  = {if_e.o_done, if_d.o_done, if_c.o_done, if_b.o_done, if_a.o_done};
   assign obs_det   = {if_e.o_seq_detected, if_d.o_seq_detected, if_c.o_seq_detected,
                       if_b.o_seq_detected, if_a.o_seq_detected};
   assign obs_cnt[0] = if_a.o_seq_count;
   assign obs_cnt[1] = if_b.o_seq_count;
   assign obs_cnt[2] = if_c.o_seq_count;
   assign obs_cnt[3] = if_d.o_seq_count;
   assign obs_cnt[4] = 16'(if_e.o_seq_count);

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model: expected serial stream, detect pulses and running count.
   task automatic model_frame(input int k, input int seed);
      int word, hist, fill, cnt, b;
      int mask, pmask, cmax;
      bit m;
      mask  = (1 << CFG_DW[k]) - 1;
      pmask = (1 << CFG_PW[k]) - 1;
      cmax  = (1 << CFG_CW[k]) - 1;
      word  = seed & mask;
      hist  = 0;
      fill  = 0;
      cnt   = 0;
      for (int w = 0; w < CFG_NW[k]; w++) begin
         for (int i = 0; i < CFG_DW[k]; i++) begin
            b = (CFG_MSB[k] != 0) ? ((word >> (CFG_DW[k] - 1 - i)) & 1) : ((word >> i) & 1);
            hist = ((hist << 1) | b) & pmask;
            if (fill < CFG_PW[k]) fill++;
            m = (fill == CFG_PW[k]) && (hist == CFG_PAT[k]);
            if (m) begin
               if (cnt < cmax) cnt++;
               if (CFG_OV[k] == 0) fill = 0;
            end
            q_bit.push_back(b[0]);
            q_det.push_back(m);
            q_cnt.push_back(cnt);
         end
         word = (word + 1) & mask;
      end
   endtask

   // Launch one frame on instance k and check it cycle by cycle against the model.
   task automatic run_frame(input int k, input int seed, input bit glitch);
      bit exp_det;
      int exp_cnt;
      int n;
      model_frame(k, seed);
      @(negedge clk);
      seed_v[k]  = 8'(seed);
      tx_en_n[k] = 1'b0;
      @(negedge clk);  // edge T has been taken: LOAD
      check($sformatf("k%0d_load_busy", k),  32'(obs_busy[k]),  32'd1);
      check($sformatf("k%0d_load_valid", k), 32'(obs_valid[k]), 32'd0);
      check($sformatf("k%0d_load_cnt", k),   32'(obs_cnt[k]),   32'd0);
      tx_en_n[k] = 1'b1;
      @(negedge clk);  // first bit on the line
      exp_det = 1'b0;
      exp_cnt = 0;
      n = 0;
      while (q_bit.size() > 0) begin
         check($sformatf("k%0d_valid%0d", k, n), 32'(obs_valid[k]), 32'd1);
         check($sformatf("k%0d_bit%0d", k, n),   32'(obs_data[k]),  32'(q_bit.pop_front()));
         check($sformatf("k%0d_det%0d", k, n),   32'(obs_det[k]),   32'(exp_det));
         check($sformatf("k%0d_cnt%0d", k, n),   32'(obs_cnt[k]),   32'(exp_cnt));
         exp_det = q_det.pop_front();
         exp_cnt = q_cnt.pop_front();
         n++;
         if (glitch && n == 3) tx_en_n[k] = 1'b0;
         if (glitch && n == 5) tx_en_n[k] = 1'b1;
         @(negedge clk);
      end
      check($sformatf("k%0d_done", k),       32'(obs_done[k]),  32'd1);
      check($sformatf("k%0d_done_valid", k), 32'(obs_valid[k]), 32'd0);
      check($sformatf("k%0d_done_busy", k),  32'(obs_busy[k]),  32'd1);
      check($sformatf("k%0d_done_det", k),   32'(obs_det[k]),   32'(exp_det));
      check($sformatf("k%0d_done_cnt", k),   32'(obs_cnt[k]),   32'(exp_cnt));
      @(negedge clk);
      check($sformatf("k%0d_post_done", k), 32'(obs_done[k]), 32'd0);
      check($sformatf("k%0d_post_busy", k), 32'(obs_busy[k]), 32'd0);
      check($sformatf("k%0d_post_cnt", k),  32'(obs_cnt[k]),  32'(exp_cnt));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tx_en_n[k] = 1'b1;
         seed_v[k]  = 8'h00;
      end
      repeat (2) @(negedge clk);

      // Reset values on every instance.
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rst_k%0d_data", k),  32'(obs_data[k]),  32'd0);
         check($sformatf("rst_k%0d_valid", k), 32'(obs_valid[k]), 32'd0);
         check($sformatf("rst_k%0d_busy", k),  32'(obs_busy[k]),  32'd0);
         check($sformatf("rst_k%0d_done", k),  32'(obs_done[k]),  32'd0);
         check($sformatf("rst_k%0d_det", k),   32'(obs_det[k]),   32'd0);
         check($sformatf("rst_k%0d_cnt", k),   32'(obs_cnt[k]),   32'd0);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst_busy", 32'(obs_busy), 32'd0);

      // Reference frame: stream 1011 1100, one match.
      run_frame(0, 'b1011, 1'b0);
      check("a_ref_count", 32'(obs_cnt[0]), 32'd1);
      // Word wrap F -> 0.
      run_frame(0, 'hF, 1'b0);
      // Restart with a new seed, plus an ignored falling edge mid-frame.
      run_frame(0, 'h3, 1'b1);
      // Overlapping versus non-overlapping detection.
      run_frame(1, 'b10101, 1'b0);
      check("b_overlap_count", 32'(obs_cnt[1]), 32'd2);
      run_frame(2, 'b10101, 1'b0);
      check("c_nonoverlap_count", 32'(obs_cnt[2]), 32'd1);
      // LSB-first bit order.
      run_frame(3, 'b0001, 1'b0);
      // Saturating 2-bit counter.
      run_frame(4, 'hF, 1'b0);
      check("e_sat_count", 32'(obs_cnt[4]), 32'd3);

      // Reset in the middle of a frame.
      @(negedge clk);
      seed_v[0]  = 8'h9;
      tx_en_n[0] = 1'b0;
      @(negedge clk);
      tx_en_n[0] = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_pre_valid", 32'(obs_valid[0]), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_data",  32'(obs_data[0]),  32'd0);
      check("midrst_valid", 32'(obs_valid[0]), 32'd0);
      check("midrst_busy",  32'(obs_busy[0]),  32'd0);
      check("midrst_done",  32'(obs_done[0]),  32'd0);
      check("midrst_det",   32'(obs_det[0]),   32'd0);
      check("midrst_cnt",   32'(obs_cnt[0]),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_busy%0d", i),  32'(obs_busy[0]),  32'd0);
         check($sformatf("post_rst_done%0d", i),  32'(obs_done[0]),  32'd0);
         check($sformatf("post_rst_valid%0d", i), 32'(obs_valid[0]), 32'd0);
      end
      // A fresh edge after reset starts a normal frame.
      run_frame(0, 'h5, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
